// File: rtl/cla_subtractor_seq_if.sv
// Operand/result handshake bundle for the chunked CLA subtractor.
// The slave side is the subtractor; the master side is the operand source plus the result consumer.
interface cla_subtractor_seq_if #(
    parameter int unsigned BITS = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] A;
    logic [BITS-1:0] B;
    logic            Bin;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] Diff;
    logic            Bout;
    logic            Ovf;
    logic            Zero;

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff, Bout, Ovf, Zero
    );

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff, Bout, Ovf, Zero
    );
endinterface

// File: rtl/cla_subtractor_seq.sv
// Multi-cycle subtractor: Diff = A + ~B + ~Bin, resolved one chunk-bit lookahead slice per cycle.
// The carry between slices is held in a register, and the borrow out is the inverted final carry.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand bundle
// RUN   | one slice per cycle, with idx running from 0 to NCH-1
// DONE  | out_valid high, result held until out_ready
module cla_subtractor_seq #(
    parameter int unsigned bits  = 8,
    parameter int unsigned chunk = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_subtractor_seq_if.slave   sub_if
);
    localparam int unsigned NCH  = (chunk == 0) ? 1 : bits / chunk;
    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCH - 1);
    localparam int unsigned MSB  = bits - 1;

    if ((chunk == 0) || (chunk > bits) || ((bits % chunk) != 0)) begin : g_bad_param
        $error("cla_subtractor_seq: bits must be a nonzero multiple of chunk");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [bits-1:0]     a_q;
    logic [bits-1:0]     nb_q;
    logic                carry_q;
    logic [IDXW-1:0]     idx_q;
    logic [bits-1:0]     diff_q;
    logic                bout_q;
    logic                ovf_q;
    logic                zero_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [chunk-1:0]    a_sl;
    logic [chunk-1:0]    b_sl;
    logic [chunk-1:0]    g;
    logic [chunk-1:0]    p;
    logic [chunk:0]      c;
    logic [chunk-1:0]    sum_sl;
    logic [bits-1:0]     diff_d;
    logic [31:0]         base;
    logic                term;
    logic                prod;

    // Every carry is expanded into a flat sum of products of g and p.
    // None of them waits on the carry of the bit below.
    always_comb begin
        base   = 32'(idx_q) * chunk;
        a_sl   = a_q[base +: chunk];
        b_sl   = nb_q[base +: chunk];
        g      = a_sl & b_sl;
        p      = a_sl ^ b_sl;
        c      = '0;
        c[0]   = carry_q;
        term   = 1'b0;
        prod   = 1'b0;
        for (int i = 0; i < int'(chunk); i++) begin
            term = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & carry_q);
        end
        sum_sl = p ^ c[chunk-1:0];
        diff_d = diff_q;
        diff_d[base +: chunk] = sum_sl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sub_if.in_valid && in_ready_q) begin
                        a_q        <= sub_if.A;
                        nb_q       <= ~sub_if.B;
                        carry_q    <= ~sub_if.Bin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    diff_q  <= diff_d;
                    carry_q <= c[chunk];
                    if (idx_q == LAST) begin
                        bout_q      <= ~c[chunk];
                        // B's sign bit is the inverse of the stored ~B.
                        ovf_q       <= (a_q[MSB] ^ ~nb_q[MSB]) & (a_q[MSB] ^ diff_d[MSB]);
                        zero_q      <= (diff_d == '0);
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (sub_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sub_if.in_ready  = in_ready_q;
    assign sub_if.out_valid = out_valid_q;
    assign sub_if.Diff      = diff_q;
    assign sub_if.Bout      = bout_q;
    assign sub_if.Ovf       = ovf_q;
    assign sub_if.Zero      = zero_q;
endmodule

// File: tb/tb_cla_subtractor_seq.sv
// Directed and swept checks of cla_subtractor_seq at chunk sizes 4, 8 and 1, with an 8-bit width.
// Instance 0 has chunk 4 and takes the directed vectors; instances 1 and 2 (chunk 8 and 1) take the random sweep.
module tb_cla_subtractor_seq;
    logic clk;
    logic rst_n;

    logic       iv   [3];
    logic       orr  [3];
    logic       binr [3];
    logic [7:0] av   [3];
    logic [7:0] bv   [3];
    logic       ir   [3];
    logic       ov   [3];
    logic       bo   [3];
    logic       of   [3];
    logic       zr   [3];
    logic [7:0] df   [3];

    int n_tests = 0;
    int n_fail  = 0;

    cla_subtractor_seq_if #(.BITS(8)) ifs [3] ();

    for (genvar k = 0; k < 3; k++) begin : g_wire
        assign ifs[k].in_valid  = iv[k];
        assign ifs[k].A         = av[k];
        assign ifs[k].B         = bv[k];
        assign ifs[k].Bin       = binr[k];
        assign ifs[k].out_ready = orr[k];
        assign ir[k] = ifs[k].in_ready;
        assign ov[k] = ifs[k].out_valid;
        assign df[k] = ifs[k].Diff;
        assign bo[k] = ifs[k].Bout;
        assign of[k] = ifs[k].Ovf;
        assign zr[k] = ifs[k].Zero;
    end

    cla_subtractor_seq #(.bits(8), .chunk(4)) u_dut_c4 (.clk(clk), .rst_n(rst_n), .sub_if(ifs[0]));
    cla_subtractor_seq #(.bits(8), .chunk(8)) u_dut_c8 (.clk(clk), .rst_n(rst_n), .sub_if(ifs[1]));
    cla_subtractor_seq #(.bits(8), .chunk(1)) u_dut_c1 (.clk(clk), .rst_n(rst_n), .sub_if(ifs[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands and waits for out_valid; lat is the number of edges after the accepting edge.
    task automatic start_op(input int s, input logic [7:0] a, input logic [7:0] b,
                            input logic bin, output int lat);
        int w;
        w = 0;
        while (!ir[s] && w < 20) begin
            tick();
            w++;
        end
        if (!ir[s]) check("accept_timeout", 32'(ir[s]), 32'd1);
        av[s] = a;
        bv[s] = b;
        binr[s] = bin;
        iv[s] = 1'b1;
        tick();
        iv[s] = 1'b0;
        lat = 0;
        while (!ov[s] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op(input int s);
        orr[s] = 1'b1;
        tick();
        orr[s] = 1'b0;
        check("ov_drop", 32'(ov[s]), 32'd0);
    endtask

    task automatic chk_out(input string tag, input int s, input logic [7:0] ed,
                           input logic eb, input logic eo, input logic ez);
        check({tag, "_diff"}, 32'(df[s]), 32'(ed));
        check({tag, "_bout"}, 32'(bo[s]), 32'(eb));
        check({tag, "_ovf"},  32'(of[s]), 32'(eo));
        check({tag, "_zero"}, 32'(zr[s]), 32'(ez));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat;
        logic [7:0] hold_d;
        logic [8:0] wide;
        int sr;
        logic [7:0] ra, rb;
        logic rbin;

        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hF0, 8'h0F, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; orr[k] = 1'b0; binr[k] = 1'b0; av[k] = '0; bv[k] = '0;
        end
        #2;
        check("rst_in_ready", 32'(ir[0]), 32'd0);
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        chk_out("rst", 0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        check("post_rst_in_ready_low", 32'(ir[0]), 32'd0);
        tick();
        check("post_rst_in_ready", 32'(ir[0]), 32'd1);

        foreach (vecs[i]) begin
            start_op(0, vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("v%0d_in_ready_done", i), 32'(ir[0]), 32'd0);
            chk_out($sformatf("v%0d", i), 0, vecs[i].d, vecs[i].bout, vecs[i].ovf, vecs[i].zero);
            finish_op(0);
        end

        // Result stays frozen in DONE under backpressure, and new operands are ignored.
        start_op(0, 8'h35, 8'h12, 1'b0, lat);
        check("hold_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            av[0] = 8'(8'hA0 + i);
            bv[0] = 8'(i);
            iv[0] = ~iv[0];
            tick();
            check("hold_out_valid", 32'(ov[0]), 32'd1);
            check("hold_in_ready", 32'(ir[0]), 32'd0);
            chk_out("hold", 0, 8'h23, 1'b0, 1'b0, 1'b0);
        end
        iv[0] = 1'b0;
        finish_op(0);
        check("after_hold_in_ready", 32'(ir[0]), 32'd1);
        start_op(0, 8'h12, 8'h35, 1'b0, lat);
        check("after_hold_latency", 32'(lat), 32'd2);
        chk_out("after_hold", 0, 8'hDD, 1'b1, 1'b0, 1'b0);
        finish_op(0);

        // Abort in the middle of RUN.
        av[0] = 8'h44; bv[0] = 8'h01; binr[0] = 1'b0; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        check("mid_run_no_valid", 32'(ov[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(ov[0]), 32'd0);
        check("abort_in_ready", 32'(ir[0]), 32'd0);
        chk_out("abort", 0, 8'h00, 1'b0, 1'b0, 1'b0);
        hold_d = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_hold_valid", 32'(ov[0]), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_abort_no_valid", 32'(ov[0]), 32'd0);
        end
        start_op(0, 8'h80, 8'h01, 1'b0, lat);
        check("post_abort_latency", 32'(lat), 32'd2);
        chk_out("post_abort", 0, 8'h7F, 1'b0, 1'b1, 1'b0);
        finish_op(0);
        check("post_abort_diff_was", 32'(hold_d), 32'd0);

        // Random sweeps on the full-width and single-bit chunk builds, checked against an arithmetic model.
        for (int s = 1; s < 3; s++) begin
            for (int n = 0; n < 1000; n++) begin
                ra   = 8'($urandom_range(0, 255));
                rb   = 8'($urandom_range(0, 255));
                rbin = 1'($urandom_range(0, 1));
                if (n == 0) begin ra = 8'h55; rb = 8'h55; rbin = 1'b1; end
                if (n == 1) begin ra = 8'h80; rb = 8'h01; rbin = 1'b0; end
                wide = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
                sr   = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
                start_op(s, ra, rb, rbin, lat);
                check($sformatf("sweep_c%0d_latency", (s == 1) ? 8 : 1), 32'(lat),
                      (s == 1) ? 32'd1 : 32'd8);
                chk_out($sformatf("sweep_c%0d", (s == 1) ? 8 : 1), s, wide[7:0], wide[8],
                        (sr > 127) || (sr < -128), wide[7:0] == 8'h00);
                finish_op(s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
